// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder/subtractor: default operand width
// and FSM state encodings.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] ST_RUN  = 2'd1;
  localparam logic [STATE_W-1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle of the serial adder. The master drives the operands and
// start; the slave returns busy/done, the result flags and its FSM state.
interface serial_adder_if
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  // Handshake: start is a request that the slave accepts only on an edge where
  // busy is low; done is a single-cycle pulse. No backpressure on the result.
  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               cin;
  logic               sub;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   sum;
  logic               cout;
  logic               overflow;
  logic [STATE_W-1:0] dbg_state;

  modport master (
    output start, a, b, cin, sub,
    input  busy, done, sum, cout, overflow, dbg_state
  );

  modport slave (
    input  start, a, b, cin, sub,
    output busy, done, sum, cout, overflow, dbg_state
  );

endinterface

// File: rtl/full_adder.sv
// One-bit full adder; the only arithmetic element of the serial adder datapath.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder slice processes one bit per cycle,
// LSB first, over WIDTH cycles, then presents the result with a one-cycle done.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic          clk,
  input logic          rst_n,
  serial_adder_if.slave bus
);

  localparam int              CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [STATE_W-1:0] state_q, state_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic               fa_sum;
  logic               fa_cout;

  full_adder u_fa (
    .a    (opa_q[0]),
    .b    (opb_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    carry_d = carry_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          // Subtraction is A + ~B + 1, so invert B and force the carry-in.
          opa_d   = bus.a;
          opb_d   = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub ? 1'b1 : bus.cin;
          res_d   = '0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        res_d   = {fa_sum, res_q[WIDTH-1:1]};
        carry_d = fa_cout;
        opa_d   = opa_q >> 1;
        opb_d   = opb_q >> 1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          // Here carry_q is the carry into the MSB and fa_cout the carry out.
          sum_d   = {fa_sum, res_q[WIDTH-1:1]};
          cout_d  = fa_cout;
          ovf_d   = carry_q ^ fa_cout;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      carry_q <= 1'b0;
      res_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      carry_q <= carry_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.overflow  = ovf_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: a WIDTH=8 instance for directed and random traffic and
// a WIDTH=2 instance driven exhaustively back-to-back, both checked every cycle.
module tb_serial_adder;
  import serial_adder_pkg::*;

  localparam int W8 = 8;
  localparam int W2 = 2;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(W8)) bus8 ();
  serial_adder_if #(.WIDTH(W2)) bus2 ();

  serial_adder #(.WIDTH(W8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  serial_adder #(.WIDTH(W2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  int checks = 0;
  int errors = 0;
  int done_seen8 = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Result as {overflow, cout, sum[31:0]} from plain integer arithmetic.
  function automatic logic [33:0] ref_calc(input logic [31:0] a, input logic [31:0] b,
                                           input logic cin, input logic sub, input int w);
    longint ua, ub, mask, full, sa, sb, res, lim;
    logic [33:0] r;
    mask = (longint'(1) << w) - 1;
    ua   = longint'(a) & mask;
    ub   = longint'(b) & mask;
    full = sub ? ua + ((~ub) & mask) + 1 : ua + ub + longint'(cin);
    sa   = (((ua >> (w - 1)) & 1) != 0) ? ua - (longint'(1) << w) : ua;
    sb   = (((ub >> (w - 1)) & 1) != 0) ? ub - (longint'(1) << w) : ub;
    res  = sub ? sa - sb : sa + sb + longint'(cin);
    lim  = longint'(1) << (w - 1);
    r        = '0;
    r[31:0]  = 32'(full & mask);
    r[32]    = ((full >> w) & 1) != 0;
    r[33]    = (res >= lim) || (res < -lim);
    return r;
  endfunction

  // ---------------- reference model (timing + expected queue) ----------------
  logic [33:0] exp8_q[$];
  logic [33:0] exp2_q[$];
  int          rem8 = 0;
  int          rem2 = 0;
  logic [7:0]  es8 = '0;
  logic        ec8 = 1'b0, eo8 = 1'b0;
  logic [1:0]  es2 = '0;
  logic        ec2 = 1'b0, eo2 = 1'b0;

  // rem counts busy cycles still to come; the last one is the done cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem8 <= 0; es8 <= '0; ec8 <= 1'b0; eo8 <= 1'b0; exp8_q.delete();
      rem2 <= 0; es2 <= '0; ec2 <= 1'b0; eo2 <= 1'b0; exp2_q.delete();
    end else begin
      if (rem8 == 0) begin
        if (bus8.start === 1'b1) begin
          exp8_q.push_back(ref_calc(32'(bus8.a), 32'(bus8.b), bus8.cin, bus8.sub, W8));
          rem8 <= W8 + 1;
        end
      end else begin
        if (rem8 == 2) begin
          es8 <= exp8_q[0][7:0]; ec8 <= exp8_q[0][32]; eo8 <= exp8_q[0][33];
          exp8_q.delete(0);
        end
        rem8 <= rem8 - 1;
      end
      if (rem2 == 0) begin
        if (bus2.start === 1'b1) begin
          exp2_q.push_back(ref_calc(32'(bus2.a), 32'(bus2.b), bus2.cin, bus2.sub, W2));
          rem2 <= W2 + 1;
        end
      end else begin
        if (rem2 == 2) begin
          es2 <= exp2_q[0][1:0]; ec2 <= exp2_q[0][32]; eo2 <= exp2_q[0][33];
          exp2_q.delete(0);
        end
        rem2 <= rem2 - 1;
      end
    end
  end

  // ---------------- scoreboard compare, every cycle ----------------
  always @(negedge clk) begin
    check("w8_busy", bus8.busy, rem8 != 0);
    check("w8_done", bus8.done, rem8 == 1);
    check("w8_sum",  bus8.sum,  es8);
    check("w8_cout", bus8.cout, ec8);
    check("w8_ovf",  bus8.overflow, eo8);
    check("w2_busy", bus2.busy, rem2 != 0);
    check("w2_done", bus2.done, rem2 == 1);
    check("w2_sum",  bus2.sum,  es2);
    check("w2_cout", bus2.cout, ec2);
    check("w2_ovf",  bus2.overflow, eo2);
    if (bus8.done === 1'b1) done_seen8++;
  end

  // ---------------- driver tasks ----------------
  task automatic op8(input string nm, input logic [7:0] a, input logic [7:0] b,
                     input logic ci, input logic sb, input logic poke,
                     input logic [7:0] es, input logic ec, input logic eo);
    int lat, bc, d0;
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = a; bus8.b = b; bus8.cin = ci; bus8.sub = sb;
    @(negedge clk);
    // Scramble inputs after sampling: the result must not depend on them.
    bus8.start = 1'b0;
    bus8.a = 8'($urandom); bus8.b = 8'($urandom);
    bus8.cin = 1'($urandom_range(0, 1)); bus8.sub = 1'($urandom_range(0, 1));
    d0  = done_seen8;
    lat = 0;
    bc  = bus8.busy ? 1 : 0;
    while (bus8.done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
      if (poke && lat == 3) begin
        bus8.start = 1'b1; bus8.a = ~a; bus8.b = a; bus8.sub = ~sb;
      end else begin
        bus8.start = 1'b0;
      end
      if (bus8.busy === 1'b1) bc++;
    end
    bus8.start = 1'b0;
    check({nm, "_latency"}, lat, 8);
    check({nm, "_busy_cycles"}, bc, 9);
    check({nm, "_sum"}, bus8.sum, es);
    check({nm, "_cout"}, bus8.cout, ec);
    check({nm, "_ovf"}, bus8.overflow, eo);
    repeat (12) @(negedge clk);
    check({nm, "_done_pulses"}, done_seen8 - d0, 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int d0, t;
    logic [5:0] c;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0; bus8.sub = 1'b0;
    bus2.start = 1'b0; bus2.a = '0; bus2.b = '0; bus2.cin = 1'b0; bus2.sub = 1'b0;

    // Pin the model against hand-computed values.
    check("model_0f_01",   ref_calc(32'h0F, 32'h01, 1'b0, 1'b0, 8), {1'b0, 1'b0, 32'h10});
    check("model_ff_01_c", ref_calc(32'hFF, 32'h01, 1'b1, 1'b0, 8), {1'b0, 1'b1, 32'h01});
    check("model_7f_01",   ref_calc(32'h7F, 32'h01, 1'b0, 1'b0, 8), {1'b1, 1'b0, 32'h80});
    check("model_05_m_07", ref_calc(32'h05, 32'h07, 1'b0, 1'b1, 8), {1'b0, 1'b0, 32'hFE});
    check("model_80_m_01", ref_calc(32'h80, 32'h01, 1'b0, 1'b1, 8), {1'b1, 1'b1, 32'h7F});
    check("model_w2_3_3_c", ref_calc(32'h3, 32'h3, 1'b1, 1'b0, 2), {1'b0, 1'b1, 32'h3});
    check("model_w2_2_m_1", ref_calc(32'h2, 32'h1, 1'b0, 1'b1, 2), {1'b1, 1'b1, 32'h1});

    // Start held high during reset must not launch anything.
    bus8.start = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_busy", bus8.busy, 1'b0);
    check("reset_done", bus8.done, 1'b0);
    check("reset_sum",  bus8.sum,  8'h00);
    check("reset_state", bus8.dbg_state, ST_IDLE);
    bus8.start = 1'b0;
    rst_n = 1'b1;

    op8("add_0f_01",   8'h0F, 8'h01, 1'b0, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
    op8("add_ff_01_c", 8'hFF, 8'h01, 1'b1, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0);
    op8("add_7f_01",   8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    op8("sub_05_07",   8'h05, 8'h07, 1'b1, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0);
    op8("sub_80_01",   8'h80, 8'h01, 1'b0, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1);
    op8("poke_mid_run", 8'h3C, 8'h5A, 1'b1, 1'b0, 1'b1, 8'h97, 1'b0, 1'b1);

    // Reset during RUN cycle 4: outputs clear at once, no done appears.
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = 8'h33; bus8.b = 8'h44; bus8.cin = 1'b0; bus8.sub = 1'b0;
    @(negedge clk);
    bus8.start = 1'b0;
    d0 = done_seen8;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrun_rst_busy", bus8.busy, 1'b0);
    check("midrun_rst_done", bus8.done, 1'b0);
    check("midrun_rst_sum",  bus8.sum,  8'h00);
    check("midrun_rst_cout", bus8.cout, 1'b0);
    check("midrun_rst_ovf",  bus8.overflow, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("midrun_rst_no_done", done_seen8 - d0, 0);
    op8("after_reset", 8'hA5, 8'h5A, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

    // Random traffic: start toggles freely, including while busy.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      bus8.start = 1'($urandom_range(0, 1));
      bus8.a     = 8'($urandom);
      bus8.b     = 8'($urandom);
      bus8.cin   = 1'($urandom_range(0, 1));
      bus8.sub   = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (12) @(negedge clk);

    // WIDTH=2 exhaustive, each operation launched in the first idle cycle.
    for (int k = 0; k < 64; k++) begin
      c = 6'(k);
      bus2.start = 1'b1;
      bus2.a = c[1:0]; bus2.b = c[3:2]; bus2.cin = c[4]; bus2.sub = c[5];
      t = 0;
      while (bus2.busy !== 1'b0 && t < 20) begin
        @(negedge clk);
        t++;
      end
      @(negedge clk);
      check("w2_accepted", bus2.busy, 1'b1);
    end
    bus2.start = 1'b0;
    repeat (8) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
